// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/redirect/pulse/counter out.
// The master side is the pipeline (or a bench); the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int STAGES = 5,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
);
  logic              ex_pc_ena;
  logic [PC_W-1:0]   ex_pc_data;
  logic [PC_W-1:0]   id_pc_data;
  logic              load_use_hazard;
  logic              mem_busy;
  logic              mdu_req;
  logic              mdu_out_valid;
  logic              fence_req;
  logic [STAGES-1:0] stage_valid;
  logic              icache_flush_done;

  logic [STAGES-1:0] stall_mask;
  logic [STAGES-1:0] flush_mask;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              mdu_start;
  logic              mdu_kill;
  logic              icache_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output ex_pc_ena, ex_pc_data, id_pc_data, load_use_hazard, mem_busy,
           mdu_req, mdu_out_valid, fence_req, stage_valid, icache_flush_done,
    input  stall_mask, flush_mask, redirect_valid, redirect_pc, mdu_start,
           mdu_kill, icache_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  ex_pc_ena, ex_pc_data, id_pc_data, load_use_hazard, mem_busy,
           mdu_req, mdu_out_valid, fence_req, stage_valid, icache_flush_done,
    output stall_mask, flush_mask, redirect_valid, redirect_pc, mdu_start,
           mdu_kill, icache_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush masks from memory wait,
// mispredict, fence.i, multi-cycle MDU and load-use, with an MDU handshake FSM,
// a fence.i drain/icache-flush FSM and saturating stall/flush counters.
// mdu_start/mdu_kill are decoded in the cycle the MDU FSM decision is taken;
// icache_flush comes from a flop set on entry to IFLUSH.
module pipeline_hazard_ctrl #(
  parameter int STAGES = 5,
  parameter int EX_IDX = 2,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_t;
  typedef enum logic [1:0] {FN_IDLE, FN_DRAIN, FN_IFLUSH, FN_REFETCH} fence_state_t;

  mdu_state_t   mdu_state_reg, mdu_state_next;
  fence_state_t fence_state_reg, fence_state_next;
  logic [PC_W-1:0]  refetch_pc_reg, refetch_pc_next;
  logic             icache_flush_reg, icache_flush_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic [STAGES-1:0] upto_ex_mask;   // stages 0..EX_IDX
  logic [STAGES-1:0] below_ex_mask;  // stages 0..EX_IDX-1
  logic [STAGES-1:0] ex_mask;        // stage EX_IDX
  logic [STAGES-1:0] post_ex_mask;   // stage EX_IDX+1
  logic [STAGES-1:0] tail_mask;      // stages EX_IDX+1..STAGES-1
  logic [STAGES-1:0] front_mask;     // stages 0..1

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_masks
      assign upto_ex_mask[gi]  = (gi <= EX_IDX);
      assign below_ex_mask[gi] = (gi < EX_IDX);
      assign ex_mask[gi]       = (gi == EX_IDX);
      assign post_ex_mask[gi]  = (gi == EX_IDX + 1);
      assign tail_mask[gi]     = (gi > EX_IDX);
      assign front_mask[gi]    = (gi <= 1);
    end
  endgenerate

  logic              mispredict;
  logic              tail_drained;
  logic              mdu_launch;
  logic [STAGES-1:0] stall_c, flush_c;
  logic              redirect_valid_c;
  logic [PC_W-1:0]   redirect_pc_c;
  logic              mdu_start_c, mdu_kill_c, flush_event_c;

  assign mispredict   = hz.ex_pc_ena & (hz.ex_pc_data != hz.id_pc_data);
  assign tail_drained = ~|(hz.stage_valid & tail_mask);
  // fence.i in EX beats a simultaneous MDU request, so it suppresses the launch
  assign mdu_launch   = (mdu_state_reg == MDU_IDLE) & hz.mdu_req & ~hz.mdu_out_valid &
                        ~hz.fence_req & (fence_state_reg == FN_IDLE) &
                        ~hz.mem_busy & ~mispredict;

  // Priority resolution of hazard sources plus next-state for both FSMs
  always_comb begin
    mdu_state_next    = mdu_state_reg;
    fence_state_next  = fence_state_reg;
    refetch_pc_next   = refetch_pc_reg;
    icache_flush_next = 1'b0;
    stall_c           = '0;
    flush_c           = '0;
    redirect_valid_c  = 1'b0;
    redirect_pc_c     = '0;
    mdu_start_c       = 1'b0;
    mdu_kill_c        = 1'b0;
    flush_event_c     = 1'b0;

    if (hz.mem_busy) begin
      stall_c = '1;
    end else if (mispredict) begin
      flush_c          = upto_ex_mask;
      redirect_valid_c = 1'b1;
      redirect_pc_c    = hz.ex_pc_data;
      flush_event_c    = 1'b1;
      mdu_kill_c       = (mdu_state_reg != MDU_IDLE);
      mdu_state_next   = MDU_IDLE;
      fence_state_next = FN_IDLE;
    end else begin
      case (fence_state_reg)
        FN_IDLE: if (hz.fence_req) begin
          fence_state_next = FN_DRAIN;
          refetch_pc_next  = hz.id_pc_data + PC_W'(4);
        end
        FN_DRAIN: if (tail_drained) begin
          fence_state_next  = FN_IFLUSH;
          icache_flush_next = 1'b1;
        end
        FN_IFLUSH:  if (hz.icache_flush_done) fence_state_next = FN_REFETCH;
        default:    fence_state_next = FN_IDLE;
      endcase

      case (mdu_state_reg)
        MDU_IDLE: if (mdu_launch) begin
          mdu_state_next = MDU_BUSY;
          mdu_start_c    = 1'b1;
        end
        MDU_BUSY: if (hz.mdu_out_valid) mdu_state_next = MDU_DONE;
        default:  mdu_state_next = MDU_IDLE;
      endcase

      if (fence_state_reg == FN_DRAIN || fence_state_reg == FN_IFLUSH) begin
        stall_c = upto_ex_mask;
        flush_c = post_ex_mask;
      end else if (fence_state_reg == FN_REFETCH) begin
        flush_c          = below_ex_mask;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = refetch_pc_reg;
      end else if (mdu_state_reg == MDU_BUSY || mdu_launch) begin
        // DONE releases the stall so EX advances with the result
        stall_c = upto_ex_mask;
        flush_c = post_ex_mask;
      end else if (hz.load_use_hazard) begin
        stall_c = front_mask;
        flush_c = ex_mask;
      end
    end
  end

  // FSM state, refetch PC latch, icache pulse flop and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_state_reg    <= MDU_IDLE;
      fence_state_reg  <= FN_IDLE;
      refetch_pc_reg   <= '0;
      icache_flush_reg <= 1'b0;
      stall_cnt_reg    <= '0;
      flush_cnt_reg    <= '0;
    end else begin
      mdu_state_reg    <= mdu_state_next;
      fence_state_reg  <= fence_state_next;
      refetch_pc_reg   <= refetch_pc_next;
      icache_flush_reg <= icache_flush_next;
      if ((|stall_c) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_event_c && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign hz.stall_mask     = stall_c;
  assign hz.flush_mask     = flush_c;
  assign hz.redirect_valid = redirect_valid_c;
  assign hz.redirect_pc    = redirect_pc_c;
  assign hz.mdu_start      = mdu_start_c;
  assign hz.mdu_kill       = mdu_kill_c;
  assign hz.icache_flush   = icache_flush_reg;
  assign hz.stall_cnt      = stall_cnt_reg;
  assign hz.flush_cnt      = flush_cnt_reg;

endmodule
